// File: rtl/unshuffle_pkg.sv
// Shared types and the pixel-to-byte mapping of the space-to-depth word layout.
package unshuffle_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam int WORD_BYTES = 16;
  localparam int BANKS      = 4;

  // Byte lane of pixel (y, x) inside its 4x4 tile word; byte 15 is the MSB byte.
  function automatic logic [3:0] byte_index(input int y, input int x);
    int ch, pos;
    ch  = (y % 2) * 2 + (x % 2);
    pos = ((y / 2) % 2) * 2 + ((x / 2) % 2);
    return 4'(WORD_BYTES - 1 - (ch * 4 + pos));
  endfunction
endpackage

// File: rtl/unshuffle_word_pack.sv
// Places one 4-pixel tile-row segment into its 16-byte word lanes; purely combinational.
module unshuffle_word_pack
  import unshuffle_pkg::*;
#(
  parameter int BW_PER_ACT = 8
) (
  input  logic [1:0]                         r,
  input  logic [4*BW_PER_ACT-1:0]            acts,
  output logic [WORD_BYTES*BW_PER_ACT-1:0]   wdata,
  output logic [WORD_BYTES-1:0]              bytemask
);

  always_comb begin
    wdata    = '0;
    bytemask = '1;
    // acts[0] is the leftmost pixel of the segment (x % 4 == 0)
    for (int k = 0; k < 4; k++) begin
      wdata[byte_index(int'(r), k)*BW_PER_ACT +: BW_PER_ACT] = acts[k*BW_PER_ACT +: BW_PER_ACT];
      bytemask[byte_index(int'(r), k)] = 1'b0;
    end
  end

endmodule

// File: rtl/unshuffle_stream.sv
// Raster-order activation stream to 4-bank space-to-depth SRAM writer with start/done control.
// Optional UNSHUFFLE_STALL_CNT_EN adds stall_cnt, a saturating count of RUN cycles without in_valid.
module unshuffle_stream
  import unshuffle_pkg::*;
#(
  parameter int IMG_W        = 28,
  parameter int IMG_H        = 28,
  parameter int BW_PER_ACT   = 8,
  parameter int CH_NUM       = 4,
  parameter int ACT_PER_ADDR = 4,
  parameter int ADDR_W       = 6
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [BW_PER_ACT-1:0]                     in_data,
  output logic                                      busy,
  output logic                                      done,
`ifdef UNSHUFFLE_STALL_CNT_EN
  output logic [15:0]                               stall_cnt,
`endif
  output logic [3:0]                                sram_wen,
  output logic [CH_NUM*ACT_PER_ADDR-1:0]            sram_bytemask,
  output logic [ADDR_W-1:0]                         sram_waddr,
  output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata
);

  localparam int WORDS_PER_ROW = (IMG_W + 7) / 8;
  localparam int WORDS         = ((IMG_H + 7) / 8) * WORDS_PER_ROW;

  if (IMG_W % 4 != 0 || IMG_W < 4 || IMG_W > 256) begin : g_bad_img_w
    $error("IMG_W must be a multiple of 4 in 4..256");
  end
  if (IMG_H % 4 != 0 || IMG_H < 4 || IMG_H > 256) begin : g_bad_img_h
    $error("IMG_H must be a multiple of 4 in 4..256");
  end
  if (CH_NUM != 4 || ACT_PER_ADDR != 4 || CH_NUM * ACT_PER_ADDR != WORD_BYTES) begin : g_bad_word
    $error("CH_NUM and ACT_PER_ADDR are fixed at 4");
  end
  if ((2 ** ADDR_W) < WORDS) begin : g_bad_addr_w
    $error("ADDR_W too narrow for the image");
  end

  state_t                  state, state_nx;
  logic [7:0]              x, y;
  logic [3*BW_PER_ACT-1:0] sh;
  logic                    accept, seg_end, last_px;
  logic [ADDR_W-1:0]       addr;
  logic [WORD_BYTES*BW_PER_ACT-1:0] pack_data;
  logic [WORD_BYTES-1:0]   pack_mask;

  assign accept  = in_valid && (state == RUN);
  assign seg_end = (x[1:0] == 2'd3);
  assign last_px = (x == 8'(IMG_W - 1)) && (y == 8'(IMG_H - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_px) state_nx = FLUSH;
      end
      FLUSH: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x  <= '0;
      y  <= '0;
      sh <= '0;
    end else if (state == IDLE && start) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      sh <= {in_data, sh[3*BW_PER_ACT-1:BW_PER_ACT]};
      if (x == 8'(IMG_W - 1)) begin
        x <= '0;
        y <= (y == 8'(IMG_H - 1)) ? 8'd0 : y + 8'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

  // Two tiles share a word address per direction; the low tile bits pick the bank.
  assign addr = ADDR_W'(y[7:3]) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(x[7:3]);

  unshuffle_word_pack #(.BW_PER_ACT(BW_PER_ACT)) u_pack (
    .r        (y[1:0]),
    .acts     ({in_data, sh}),
    .wdata    (pack_data),
    .bytemask (pack_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_wen      <= 4'hF;
      sram_bytemask <= '1;
      sram_waddr    <= '0;
      sram_wdata    <= '0;
    end else if (accept && seg_end) begin
      sram_wen      <= ~(4'b0001 << {y[2], x[2]});
      sram_bytemask <= pack_mask;
      sram_waddr    <= addr;
      sram_wdata    <= pack_data;
    end else begin
      sram_wen      <= 4'hF;
      sram_bytemask <= '1;
      sram_wdata    <= '0;
    end
  end

`ifdef UNSHUFFLE_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            stall_cnt <= '0;
    else if (state == IDLE && start)                    stall_cnt <= '0;
    else if (state == RUN && !in_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_unshuffle_stream.sv
// Directed bench: an 8x8 instance for layout/timing/abort cases and a default 28x28 instance.
module tb_unshuffle_stream;
  import unshuffle_pkg::*;

  logic         clk = 1'b0;
  logic         rst, start8, start28, in_valid;
  logic [7:0]   in_data;
  logic         rdy8, busy8, done8, rdy28, busy28, done28;
  logic [3:0]   wen8, wen28;
  logic [15:0]  mask8, mask28;
  logic [5:0]   addr8, addr28;
  logic [127:0] data8, data28;
`ifdef UNSHUFFLE_STALL_CNT_EN
  logic [15:0]  stall8, stall28;
`endif

  always #5 clk = ~clk;

  unshuffle_stream #(.IMG_W(8), .IMG_H(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in_data), .busy(busy8), .done(done8),
`ifdef UNSHUFFLE_STALL_CNT_EN
    .stall_cnt(stall8),
`endif
    .sram_wen(wen8), .sram_bytemask(mask8), .sram_waddr(addr8), .sram_wdata(data8)
  );

  unshuffle_stream dut28 (
    .clk(clk), .rst(rst), .start(start28), .in_valid(in_valid), .in_ready(rdy28),
    .in_data(in_data), .busy(busy28), .done(done28),
`ifdef UNSHUFFLE_STALL_CNT_EN
    .stall_cnt(stall28),
`endif
    .sram_wen(wen28), .sram_bytemask(mask28), .sram_waddr(addr28), .sram_wdata(data28)
  );

  int vec = 0, errs = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: record {wen, addr, mask, data}, cycle counts and unexpected writes
  logic [153:0] q8[$];
  logic [153:0] qa[$];
  int  c8 = 0, first_wr_cyc = 0, done8_cnt = 0, done8_cyc = 0;
  int  stray8 = 0, missing8 = 0, acc8 = 0;
  bit  exp_wr8 = 0;
  int  wr28 = 0, done28_cnt = 0, t66_cnt = 0;
  bit  t66_seen = 0;
  logic [15:0]  t66_mask = '0;
  logic [127:0] t66_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      acc8    = 0;
      exp_wr8 = 0;
    end else begin
      if (start8 && !busy8) begin c8 = 0; acc8 = 0; end
      else c8++;
      if (wen8 !== 4'hF) begin
        q8.push_back({wen8, addr8, mask8, data8});
        if (q8.size() == 1) first_wr_cyc = c8;
        if (!exp_wr8) stray8++;
      end else if (exp_wr8) missing8++;
      exp_wr8 = in_valid && rdy8 && (acc8 % 4 == 3);
      if (in_valid && rdy8) acc8++;
      if (done8) begin done8_cnt++; done8_cyc = c8; end
      if (wen28 !== 4'hF) begin
        wr28++;
        if (addr28 == 6'd15 && wen28 == 4'b1110) begin
          t66_cnt++;
          if (!t66_seen) begin t66_seen = 1; t66_mask = mask28; t66_data = data28; end
        end
      end
      if (done28) done28_cnt++;
    end
  end

  task automatic do_start(input bit big);
    if (big) start28 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start8  = 1'b0;
    start28 = 1'b0;
  endtask

  // Feeds pixel index as data; optional single-cycle gaps before pixels 3,9,..,57 (10 gaps)
  task automatic run_pixels(input bit big, input int npix, input bit gaps, input int start_at);
    int idx = 0, budget = 0;
    bit gapped = 0, r;
    while (idx < npix && budget < 5000) begin
      if (gaps && idx % 6 == 3 && idx < 60 && !gapped) begin in_valid = 1'b0; gapped = 1; end
      else in_valid = 1'b1;
      in_data = 8'(idx);
      start8  = !big && (idx == start_at);
      r = big ? rdy28 : rdy8;
      @(posedge clk); #1;
      budget++;
      if (in_valid && r) begin idx++; gapped = 0; end
    end
    in_valid = 1'b0;
    start8   = 1'b0;
    chk("pixel_budget", budget < 5000, 1);
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start28 = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", rdy8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_wen", wen8, 4'hF);
    chk("rst_mask", mask8, 16'hFFFF);
    chk("rst_addr", addr8, 0);
    chk("rst_data", data8, 0);
    chk("rst_wen28", wen28, 4'hF);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame A: 8x8 gap-free, with an ignored start pulse mid-frame
    q8.delete();
    do_start(0);
    run_pixels(0, 64, 0, 20);
    repeat (3) @(posedge clk);
    #1;
    qa = q8;
    chk("a_nwrites", qa.size(), 16);
    chk("a_first_cyc", first_wr_cyc, 5);
    chk("a_done_cyc", done8_cyc, 65);
    chk("a_done_cnt", done8_cnt, 1);
    chk("a_stray", stray8, 0);
    chk("a_missing", missing8, 0);
    if (qa.size() == 16) begin
      chk("a_w1_wen", qa[0][153:150], 4'b1110);
      chk("a_w1_addr", qa[0][149:144], 0);
      chk("a_w1_mask", qa[0][143:128], 16'h33FF);
      chk("a_w1_data", qa[0][127:0], 128'h00020000_01030000_00000000_00000000);
      chk("a_w2_wen", qa[1][153:150], 4'b1101);
      chk("a_row1_wen", qa[2][153:150], 4'b1110);
      chk("a_row1_mask", qa[2][143:128], 16'hFF33);
      chk("a_row1_data", qa[2][127:0], 128'h00000000_00000000_080A0000_090B0000);
      chk("a_row4_wen0", qa[8][153:150], 4'b1011);
      chk("a_row4_wen1", qa[9][153:150], 4'b0111);
      for (int k = 0; k < 16; k++) begin
        int yy, s;
        logic [127:0] d;
        logic [15:0]  m;
        logic [3:0]   w;
        yy = k / 2; s = k % 2;
        d = '0; m = '1; w = 4'hF;
        for (int i = 0; i < 4; i++) begin
          d[byte_index(yy, 4*s+i)*8 +: 8] = 8'(yy*8 + 4*s + i);
          m[byte_index(yy, 4*s+i)] = 1'b0;
        end
        w[((yy/4) % 2) * 2 + s] = 1'b0;
        chk($sformatf("a_model_wr%0d", k), qa[k], {w, 6'd0, m, d});
      end
    end

    // Frame B: same frame with 10 input gaps
    q8.delete();
    do_start(0);
    run_pixels(0, 64, 1, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("b_nwrites", q8.size(), 16);
    chk("b_done_cnt", done8_cnt, 2);
    chk("b_done_cyc", done8_cyc, 75);
    chk("b_stray", stray8, 0);
    chk("b_missing", missing8, 0);
    if (q8.size() == 16 && qa.size() == 16)
      for (int k = 0; k < 16; k++) chk($sformatf("b_same_wr%0d", k), q8[k], qa[k]);
`ifdef UNSHUFFLE_STALL_CNT_EN
    chk("b_stall_cnt", stall8, 16'd10);
    repeat (5) @(posedge clk);
    #1;
    chk("b_stall_hold", stall8, 16'd10);
`endif

    // Abort: reset while a write is on the bus, then a clean frame
    q8.delete();
    do_start(0);
    run_pixels(0, 20, 0, -1);
    chk("abort_wr_live", wen8, 4'b1110);
    #1 rst = 1'b1;
    #1;
    chk("abort_wen", wen8, 4'hF);
    chk("abort_busy", busy8, 0);
    chk("abort_ready", rdy8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_done", done8_cnt, 2);
    q8.delete();
    do_start(0);
    run_pixels(0, 64, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("c_nwrites", q8.size(), 16);
    if (q8.size() > 0) begin
      chk("c_w1_wen", q8[0][153:150], 4'b1110);
      chk("c_w1_addr", q8[0][149:144], 0);
      chk("c_w1_mask", q8[0][143:128], 16'h33FF);
    end
    chk("c_done_cnt", done8_cnt, 3);
    chk("c_done_cyc", done8_cyc, 65);

    // 28x28 default-size frame
    do_start(1);
    run_pixels(1, 784, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("d_writes", wr28, 196);
    chk("d_done_cnt", done28_cnt, 1);
    chk("d_t66_cnt", t66_cnt, 4);
    chk("d_t66_mask", t66_mask, 16'h33FF);
    chk("d_t66_data", t66_data, 128'hB8BA0000_B9BB0000_00000000_00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
